// File: rtl/dcache_wb_if.sv
// Core-side and backing-memory signals of the write-back data cache.
// The master modport is the core/memory environment; the slave modport is the cache.
interface dcache_wb_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memwrite;
    logic        memread;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic        clk_stall;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output addr, write_data, memwrite, memread, sign_mask, mem_rdata, mem_ack,
        input  read_data, clk_stall, misaligned, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  addr, write_data, memwrite, memread, sign_mask, mem_rdata, mem_ack,
        output read_data, clk_stall, misaligned, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back data cache with line refill and dirty writeback.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_wb #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dcache_wb_if.slave    bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);
    localparam int LOG_W  = $clog2(WORDS_PER_LINE);
    localparam int BEAT_W = (LOG_W > 0) ? LOG_W : 1;
    localparam int OFF_W  = LOG_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int RAM_W  = IDX_W + LOG_W;
    localparam int RAM_D  = NUM_LINES * WORDS_PER_LINE;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_t;

    state_t                r_state, w_state_next;
    logic [31:0]           r_ram [RAM_D];
    logic [TAG_W-1:0]      r_tag [NUM_LINES];
    logic [NUM_LINES-1:0]  r_valid, r_dirty;
    logic [BEAT_W-1:0]     r_beat, w_beat_next, w_beat_sel;
    logic                  r_mem_req, w_mem_req_next;
    logic                  r_mem_we, w_mem_we_next;
    logic [31:0]           r_mem_addr, w_mem_addr_next;
    logic [31:0]           r_mem_wdata, w_mem_wdata_next;
    logic [31:0]           r_read_data;
    logic                  r_misaligned;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [BEAT_W-1:0]     w_word;
    logic                  w_req, w_mis, w_hit, w_idle, w_ok;
    logic                  w_hit_done, w_miss_start, w_ack, w_last, w_refill_done;
    logic [31:0]           w_word_rd, w_wb_rd, w_load, w_merged;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    // Word position of a line beat in the flat data array (beat bits vanish when lines are one word).
    function automatic logic [RAM_W-1:0] ram_idx(input logic [IDX_W-1:0] idx,
                                                 input logic [BEAT_W-1:0] b);
        ram_idx = RAM_W'({idx, b} >> (BEAT_W - LOG_W));
    endfunction

    function automatic logic [31:0] beat_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx,
                                              input logic [BEAT_W-1:0] b);
        beat_addr = {tag, idx, OFF_W'({b, 2'b00})};
    endfunction

    assign w_idx  = IDX_W'(bus.addr >> OFF_W);
    assign w_tag  = bus.addr[31 -: TAG_W];
    assign w_word = BEAT_W'((bus.addr >> 2) & 32'(WORDS_PER_LINE - 1));
    assign w_req  = bus.memread | bus.memwrite;
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_comb begin
        w_mis = 1'b0;
        case (bus.sign_mask[2:0])
            3'b011:  w_mis = w_req & bus.addr[0];
            3'b111:  w_mis = w_req & (|bus.addr[1:0]);
            default: w_mis = 1'b0;
        endcase
    end

    assign w_idle        = (r_state == S_IDLE);
    assign w_ok          = w_idle & w_req & ~w_mis;
    assign w_hit_done    = w_ok & w_hit;
    assign w_miss_start  = w_ok & ~w_hit;
    assign w_ack         = r_mem_req & bus.mem_ack;
    assign w_last        = (r_beat == LAST_BEAT);
    assign w_refill_done = (r_state == S_REFILL) & w_ack & w_last;

    // Beat to issue next: the current one when idle on the bus, the following one on an ack.
    assign w_beat_sel = r_mem_req ? (r_beat + BEAT_W'(1)) : r_beat;
    assign w_word_rd  = r_ram[ram_idx(w_idx, w_word)];
    assign w_wb_rd    = r_ram[ram_idx(w_idx, w_beat_sel)];
    assign w_byte     = w_word_rd[{bus.addr[1:0], 3'b000} +: 8];
    assign w_half     = w_word_rd[{bus.addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load   = w_word_rd;
        w_merged = bus.write_data;
        case (bus.sign_mask[2:0])
            3'b001: begin
                w_load   = {{24{bus.sign_mask[3] & w_byte[7]}}, w_byte};
                w_merged = (w_word_rd & ~(32'h0000_00FF << {bus.addr[1:0], 3'b000}))
                         | ({24'h0, bus.write_data[7:0]} << {bus.addr[1:0], 3'b000});
            end
            3'b011: begin
                w_load   = {{16{bus.sign_mask[3] & w_half[15]}}, w_half};
                w_merged = (w_word_rd & ~(32'h0000_FFFF << {bus.addr[1], 4'b0000}))
                         | ({16'h0, bus.write_data[15:0]} << {bus.addr[1], 4'b0000});
            end
            default: begin
                w_load   = w_word_rd;
                w_merged = bus.write_data;
            end
        endcase
    end

    always_comb begin
        w_state_next     = r_state;
        w_beat_next      = r_beat;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_miss_start)
                    w_state_next = (r_valid[w_idx] & r_dirty[w_idx]) ? S_WRITEBACK : S_REFILL;
            end
            S_WRITEBACK: begin
                if (!r_mem_req || bus.mem_ack) begin
                    if (r_mem_req && w_last) begin
                        w_mem_req_next = 1'b0;
                        w_mem_we_next  = 1'b0;
                        w_beat_next    = '0;
                        w_state_next   = S_REFILL;
                    end else begin
                        w_mem_req_next   = 1'b1;
                        w_mem_we_next    = 1'b1;
                        w_mem_addr_next  = beat_addr(r_tag[w_idx], w_idx, w_beat_sel);
                        w_mem_wdata_next = w_wb_rd;
                        w_beat_next      = w_beat_sel;
                    end
                end
            end
            S_REFILL: begin
                if (!r_mem_req || bus.mem_ack) begin
                    if (r_mem_req && w_last) begin
                        w_mem_req_next = 1'b0;
                        w_beat_next    = '0;
                        w_state_next   = S_IDLE;
                    end else begin
                        w_mem_req_next  = 1'b1;
                        w_mem_we_next   = 1'b0;
                        w_mem_addr_next = beat_addr(w_tag, w_idx, w_beat_sel);
                        w_beat_next     = w_beat_sel;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_read_data  <= '0;
            r_misaligned <= 1'b0;
            r_valid      <= '0;
            r_dirty      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_beat       <= w_beat_next;
            r_mem_req    <= w_mem_req_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_misaligned <= w_idle & w_mis;
            if (w_idle && w_mis)
                r_read_data <= '0;
            else if (w_hit_done && !bus.memwrite)
                r_read_data <= w_load;
            if (w_hit_done && bus.memwrite)
                r_dirty[w_idx] <= 1'b1;
            if (w_refill_done) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end
        end
    end

    // Data and tags carry no reset; valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (w_hit_done && bus.memwrite)
            r_ram[ram_idx(w_idx, w_word)] <= w_merged;
        else if ((r_state == S_REFILL) && w_ack)
            r_ram[ram_idx(w_idx, r_beat)] <= bus.mem_rdata;
        if (w_refill_done)
            r_tag[w_idx] <= w_tag;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_count, r_miss_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_done && (r_hit_count != 32'hFFFF_FFFF))
                r_hit_count <= r_hit_count + 32'd1;
            if (w_miss_start && (r_miss_count != 32'hFFFF_FFFF))
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

    assign bus.read_data  = r_read_data;
    assign bus.misaligned = r_misaligned;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.clk_stall  = (r_state != S_IDLE) | (w_req & ~w_hit & ~w_mis);
endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb with a one-wait-cycle backing memory that logs every beat.
module tb_dcache_wb;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_wb_if bus();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache_wb #(.NUM_LINES(16), .WORDS_PER_LINE(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // Backing memory: unwritten words read as 0xC0DE0000 | byte address.
    logic [31:0] mem [int];
    logic        q_we    [$];
    logic [31:0] q_addr  [$];
    logic [31:0] q_wdata [$];

    always @(negedge clk) begin
        if (!rst_n || !bus.mem_req || bus.mem_ack) begin
            bus.mem_ack = 1'b0;
        end else begin
            bus.mem_ack = 1'b1;
            q_we.push_back(bus.mem_we);
            q_addr.push_back(bus.mem_addr);
            q_wdata.push_back(bus.mem_wdata);
            if (bus.mem_we)
                mem[int'(bus.mem_addr[11:2])] = bus.mem_wdata;
            else if (mem.exists(int'(bus.mem_addr[11:2])))
                bus.mem_rdata = mem[int'(bus.mem_addr[11:2])];
            else
                bus.mem_rdata = 32'hC0DE_0000 | {20'h0, bus.mem_addr[11:2], 2'b00};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int n_writes();
        int n = 0;
        foreach (q_we[i]) if (q_we[i]) n++;
        return n;
    endfunction

    // Present one request, ride out any stall, and return after the completing edge.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] mask, output int stalls);
        q_we.delete();
        q_addr.delete();
        q_wdata.delete();
        bus.addr       = a;
        bus.write_data = wd;
        bus.sign_mask  = mask;
        bus.memwrite   = we;
        bus.memread    = ~we;
        stalls = 0;
        #1;
        while (bus.clk_stall && stalls < 200) begin
            step();
            stalls++;
        end
        if (stalls >= 200) chk("stall_timeout", {31'h0, bus.clk_stall}, 32'h0);
        step();
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        $display("access we=%0d addr=0x%08h wd=0x%08h mask=%b -> rd=0x%08h mis=%0d stalls=%0d beats=%0d writes=%0d",
                 we, a, wd, mask, bus.read_data, bus.misaligned, stalls, q_we.size(), n_writes());
    endtask

    initial begin
        int st;
        bus.addr       = '0;
        bus.write_data = '0;
        bus.sign_mask  = 4'b0111;
        bus.memwrite   = 1'b0;
        bus.memread    = 1'b0;
        rst_n          = 1'b0;
        step();
        step();
        chk("rst_read_data", bus.read_data, 32'h0);
        chk("rst_misaligned", {31'h0, bus.misaligned}, 32'h0);
        chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_stall", {31'h0, bus.clk_stall}, 32'h0);
        rst_n = 1'b1;
        step();

        // Cold byte store: refill only, then merge.
        access(1'b1, 32'h400, 32'h0000_00AA, 4'b0001, st);
        chk("cold_store_stalled", {31'h0, (st > 0)}, 32'h1);
        chk("cold_store_beats", q_we.size(), 32'd4);
        chk("cold_store_writes", n_writes(), 32'd0);
        if (q_addr.size() == 4) begin
            chk("cold_beat0_addr", q_addr[0], 32'h400);
            chk("cold_beat1_addr", q_addr[1], 32'h404);
            chk("cold_beat3_addr", q_addr[3], 32'h40C);
        end

        // Hits: signed/unsigned byte, full word showing the merge.
        access(1'b0, 32'h400, 32'h0, 4'b1001, st);
        chk("ld_sbyte", bus.read_data, 32'hFFFF_FFAA);
        chk("ld_sbyte_stalls", st, 32'd0);
        chk("ld_sbyte_beats", q_we.size(), 32'd0);
        access(1'b0, 32'h400, 32'h0, 4'b0001, st);
        chk("ld_ubyte", bus.read_data, 32'h0000_00AA);
        chk("ld_ubyte_mem_req", {31'h0, bus.mem_req}, 32'h0);
        access(1'b0, 32'h400, 32'h0, 4'b0111, st);
        chk("ld_word_merged", bus.read_data, 32'hC0DE_04AA);

        // Conflict on index 0: dirty writeback then refill.
        access(1'b0, 32'h500, 32'h0, 4'b0111, st);
        chk("conf_beats", q_we.size(), 32'd8);
        chk("conf_writes", n_writes(), 32'd4);
        if (q_we.size() == 8) begin
            chk("conf_wb0_we", {31'h0, q_we[0]}, 32'h1);
            chk("conf_wb0_addr", q_addr[0], 32'h400);
            chk("conf_wb0_data", q_wdata[0], 32'hC0DE_04AA);
            chk("conf_wb3_addr", q_addr[3], 32'h40C);
            chk("conf_rf0_we", {31'h0, q_we[4]}, 32'h0);
            chk("conf_rf0_addr", q_addr[4], 32'h500);
            chk("conf_rf3_addr", q_addr[7], 32'h50C);
        end
        chk("conf_load", bus.read_data, 32'hC0DE_0500);

        // Halfword store into upper lane, evicting a clean line.
        access(1'b1, 32'h102, 32'h0000_AAAA, 4'b0011, st);
        chk("half_store_writes", n_writes(), 32'd0);
        access(1'b0, 32'h102, 32'h0, 4'b1011, st);
        chk("ld_shalf", bus.read_data, 32'hFFFF_AAAA);
        access(1'b0, 32'h102, 32'h0, 4'b0011, st);
        chk("ld_uhalf", bus.read_data, 32'h0000_AAAA);
        access(1'b0, 32'h100, 32'h0, 4'b0111, st);
        chk("ld_half_word", bus.read_data, 32'hAAAA_0100);

        // Word round trip on another index.
        access(1'b1, 32'h40, 32'hAAAA_AAAA, 4'b0111, st);
        access(1'b0, 32'h40, 32'h0, 4'b0111, st);
        chk("word_roundtrip", bus.read_data, 32'hAAAA_AAAA);
        chk("word_hit_stalls", st, 32'd0);

        // Misaligned word load.
        access(1'b0, 32'h41, 32'h0, 4'b0111, st);
        chk("mis_flag", {31'h0, bus.misaligned}, 32'h1);
        chk("mis_read_data", bus.read_data, 32'h0);
        chk("mis_stalls", st, 32'd0);
        chk("mis_beats", q_we.size(), 32'd0);
        step();
        chk("mis_one_cycle", {31'h0, bus.misaligned}, 32'h0);
        access(1'b0, 32'h40, 32'h0, 4'b0111, st);
        chk("mis_no_change", bus.read_data, 32'hAAAA_AAAA);

        // Reset during the second refill beat of a dirty-victim miss.
        q_we.delete();
        q_addr.delete();
        q_wdata.delete();
        bus.addr      = 32'h400;
        bus.sign_mask = 4'b0111;
        bus.memread   = 1'b1;
        for (int i = 0; i < 100 && !(bus.mem_req && !bus.mem_we && bus.mem_addr == 32'h404); i++)
            step();
        chk("rst_reach_beat1", {31'h0, (bus.mem_req && !bus.mem_we && bus.mem_addr == 32'h404)}, 32'h1);
        rst_n       = 1'b0;
        bus.memread = 1'b0;
        #1;
        $display("reset asserted mid-refill at %0t", $time);
        chk("midrst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("midrst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        chk("midrst_mem_addr", bus.mem_addr, 32'h0);
        chk("midrst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("midrst_read_data", bus.read_data, 32'h0);
        chk("midrst_stall", {31'h0, bus.clk_stall}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        access(1'b0, 32'h400, 32'h0, 4'b0111, st);
        chk("post_rst_beats", q_we.size(), 32'd4);
        chk("post_rst_writes", n_writes(), 32'd0);
        if (q_addr.size() > 0) chk("post_rst_addr0", q_addr[0], 32'h400);
        chk("post_rst_load", bus.read_data, 32'hC0DE_04AA);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
